// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU MEM stage
// and an external requester (loader/DMA/debug). One access at a time,
// round-robin on ties, each access sequenced over LAT memory cycles.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata CPU access, req held until cpu_ack
//   cpu_ack, cpu_rdata    one-cycle completion pulse, read data (held)
//   cpu_stall             cpu_req & ~cpu_ack, freezes the pipeline
//   ext_req/we/addr/wdata external access, req held until ext_ack
//   ext_ack, ext_rdata    one-cycle completion pulse, read data (held)
//   mem_rd, mem_wr        dm read / write strobes
//   mem_addr, mem_wdata   dm address / write data (latched at grant)
//   mem_rdata             dm read data, combinational from mem_addr
module dm_arbiter #(
  parameter int AW  = 7,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_ack,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_ack,
  output logic [31:0]   ext_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            gnt;         // 0 = CPU, 1 = EXT
  logic            last_grant;  // reset to EXT so the CPU wins the first tie
  logic            win;
  logic            l_we;
  logic [AW-1:0]   l_addr;
  logic [31:0]     l_wdata;

  // Tie goes to whichever port was not served last.
  always_comb begin
    win = ext_req;
    if (cpu_req && ext_req) win = ~last_grant;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    cpu_ack   = 1'b0;
    ext_ack   = 1'b0;
    case (state)
      IDLE: if (cpu_req || ext_req) state_nxt = BUSY;
      BUSY: begin
        mem_rd = ~l_we;
        // single write strobe on the last busy cycle
        mem_wr = l_we && (cnt == '0);
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        cpu_ack   = ~gnt;
        ext_ack   = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign mem_addr  = l_addr;
  assign mem_wdata = l_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      l_we       <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cpu_req || ext_req) begin
          gnt        <= win;
          last_grant <= win;
          l_we       <= win ? ext_we    : cpu_we;
          l_addr     <= win ? ext_addr  : cpu_addr;
          l_wdata    <= win ? ext_wdata : cpu_wdata;
          cnt        <= CW'(LAT - 1);
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (!l_we) begin
            if (gnt) ext_rdata <= mem_rdata;
            else     cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
